// File: rtl/wb_ledring.sv
// wb_ledring: Wishbone-mapped, double-buffered serial LED ring driver.
// Optional feature macro: WB_LEDRING_BRIGHTNESS_EN scales each shifted byte by CR.BRIGHT.
module wb_ledring #(
    parameter int unsigned NUM_LEDS      = 35,
    parameter int unsigned BYTES_PER_LED = 4,
    parameter int unsigned T_BIT         = 75,
    parameter int unsigned T0H           = 21,
    parameter int unsigned T1H           = 42,
    parameter int unsigned T_LATCH       = 3000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [13:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        everloop_ctl
);
    localparam int unsigned NB   = NUM_LEDS * BYTES_PER_LED;
    localparam int unsigned NW   = (NB + 1) / 2;
    localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CMAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, LATCH} state_t;

    logic [7:0]    mem0 [NB];
    logic [7:0]    mem1 [NB];

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [IW-1:0] byte_idx;
    logic [7:0]    shreg;
    logic          en;
    logic          pend;
    logic          front_idx;
    logic [7:0]    frame_cnt;
    logic [7:0]    bright_rd;
    logic [7:0]    front_byte;
    logic [7:0]    load_byte;

    logic          req;
    logic          rd;
    logic          wr;
    logic [8:0]    off;
    logic [10:0]   lo_a;
    logic [10:0]   hi_a;
    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          in_range;
    logic          hi_ok;
    logic          buf_wr;
    logic          cr_wr;
    logic [15:0]   rdata;
    logic          unused_adr;

    assign req        = wb_stb_i & wb_cyc_i;
    assign rd         = req & ~wb_we_i;
    assign wr         = req & wb_we_i;
    assign off        = wb_adr_i[8:0];
    assign lo_a       = {1'b0, off, 1'b0};
    assign hi_a       = lo_a + 11'd1;
    assign lo_idx     = IW'(lo_a);
    assign hi_idx     = IW'(hi_a);
    assign in_range   = 32'(off) < NW;
    assign hi_ok      = 32'(hi_a) < NB;
    assign buf_wr     = wr & ~wb_adr_i[9] & in_range;
    assign cr_wr      = wr & wb_adr_i[9] & (off == 9'd0);
    assign unused_adr = ^wb_adr_i[13:10];
    assign front_byte = front_idx ? mem1[byte_idx] : mem0[byte_idx];

`ifdef WB_LEDRING_BRIGHTNESS_EN
    logic [7:0] bright;
    assign bright_rd = bright;
    assign load_byte = 8'((16'(front_byte) * (16'(bright) + 16'd1)) >> 8);
`else
    assign bright_rd = 8'd0;
    assign load_byte = front_byte;
`endif

    // Bus read mux: registers, or back-buffer word (0 when out of range)
    always_comb begin
        rdata = '0;
        if (wb_adr_i[9]) begin
            if (off == 9'd0) begin
                rdata = {bright_rd, 6'd0, pend, en};
            end else if (off == 9'd1) begin
                rdata = {frame_cnt, 6'd0, front_idx, (state != IDLE)};
            end
        end else if (in_range) begin
            rdata[7:0] = front_idx ? mem0[lo_idx] : mem1[lo_idx];
            if (hi_ok) begin
                rdata[15:8] = front_idx ? mem0[hi_idx] : mem1[hi_idx];
            end
        end
    end

    // Registered read data, updated only on sampled read cycles
    always_ff @(posedge clk) begin
        if (nrst) begin
            wb_dat_o <= '0;
        end else if (rd) begin
            wb_dat_o <= rdata;
        end
    end

    // Back-buffer byte writes; contents survive reset
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            if (wb_sel_i[0]) begin
                if (front_idx) mem0[lo_idx] <= wb_dat_i[7:0];
                else           mem1[lo_idx] <= wb_dat_i[7:0];
            end
            if (wb_sel_i[1] && hi_ok) begin
                if (front_idx) mem0[hi_idx] <= wb_dat_i[15:8];
                else           mem1[hi_idx] <= wb_dat_i[15:8];
            end
        end
    end

    // Serial FSM plus control register; a CR write after the case wins over the FSM's commit clear
    always_ff @(posedge clk) begin
        if (nrst) begin
            state        <= IDLE;
            everloop_ctl <= 1'b0;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            en           <= 1'b0;
            pend         <= 1'b0;
            front_idx    <= 1'b0;
            frame_cnt    <= '0;
`ifdef WB_LEDRING_BRIGHTNESS_EN
            bright       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    everloop_ctl <= 1'b0;
                    if (pend) begin
                        front_idx <= ~front_idx;
                        pend      <= 1'b0;
                    end
                    if (en) begin
                        byte_idx <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shreg        <= load_byte;
                    bit_idx      <= 3'd7;
                    cnt          <= '0;
                    everloop_ctl <= 1'b1;
                    state        <= BIT_HI;
                end
                BIT_HI: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == (shreg[7] ? CW'(T1H - 1) : CW'(T0H - 1))) begin
                        everloop_ctl <= 1'b0;
                        state        <= BIT_LO;
                    end
                end
                BIT_LO: begin
                    if (cnt == CW'(T_BIT - 1)) begin
                        cnt <= '0;
                        if (bit_idx == 3'd0) begin
                            if (byte_idx == IW'(NB - 1)) begin
                                state <= LATCH;
                            end else begin
                                byte_idx <= byte_idx + IW'(1);
                                state    <= LOAD;
                            end
                        end else begin
                            bit_idx      <= bit_idx - 3'd1;
                            shreg        <= {shreg[6:0], 1'b0};
                            everloop_ctl <= 1'b1;
                            state        <= BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LATCH: begin
                    everloop_ctl <= 1'b0;
                    if (cnt == CW'(T_LATCH - 1)) begin
                        cnt       <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                        if (pend) begin
                            front_idx <= ~front_idx;
                            pend      <= 1'b0;
                        end
                        if (en) begin
                            byte_idx <= '0;
                            state    <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    everloop_ctl <= 1'b0;
                    state        <= IDLE;
                end
            endcase

            if (cr_wr) begin
                if (wb_sel_i[0]) begin
                    en <= wb_dat_i[0];
                    if (wb_dat_i[1]) pend <= 1'b1;
                end
`ifdef WB_LEDRING_BRIGHTNESS_EN
                if (wb_sel_i[1]) bright <= wb_dat_i[15:8];
`endif
            end
        end
    end
endmodule

// File: tb/tb_wb_ledring.sv
// tb_wb_ledring: bus vector table on a 35-LED instance, serial-stream scoreboard on a 1-LED GRB instance.
module tb_wb_ledring;
    localparam int T_BIT = 75;
    localparam int T0H = 21;
    localparam int T1H = 42;
    localparam int T_LATCH = 3000;

`ifdef WB_LEDRING_BRIGHTNESS_EN
    localparam logic [15:0] BRM = 16'hFF00;
`else
    localparam logic [15:0] BRM = 16'h0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst_s, nrst_b, cyc, we, stb_s, stb_b;
    logic [13:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [15:0] dat_o_s, dat_o_b;
    logic        ser_s, ser_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] rd_q[$];
    logic [7:0]  ser_q[$];

    wb_ledring #(.NUM_LEDS(1), .BYTES_PER_LED(3)) u_small (
        .clk(clk), .nrst(nrst_s), .wb_stb_i(stb_s), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o_s), .everloop_ctl(ser_s));

    wb_ledring u_big (
        .clk(clk), .nrst(nrst_b), .wb_stb_i(stb_b), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o_b), .everloop_ctl(ser_b));

    function automatic logic [7:0] scale(input logic [7:0] b, input logic [7:0] br);
`ifdef WB_LEDRING_BRIGHTNESS_EN
        return 8'((int'(b) * (int'(br) + 1)) / 256);
`else
        return (br == br) ? b : b;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Serial decoder: measures high/low runs on the small instance and scores bytes
    logic       mon_en = 1'b0;
    logic       prev, got_bit;
    int         run, nbits, nbyte, last_hi, exp_lo;
    logic [7:0] eb, sh;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev = ser_s; run = 0; nbits = 0; nbyte = 0; got_bit = 1'b0; sh = '0;
        end else if (ser_s === prev) begin
            run++;
        end else if (ser_s === 1'b1) begin
            if (got_bit) begin
                exp_lo = T_BIT - last_hi + ((nbits == 0) ? 1 : 0)
                       + ((nbits == 0 && nbyte == 0) ? T_LATCH : 0);
                check("low_gap", run, exp_lo);
            end
            prev = 1'b1; run = 1;
        end else begin
            if (ser_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_bit: high run %0d with no byte expected", run);
            end else begin
                eb = ser_q[0];
                check("bit_high_time", run, eb[7 - nbits] ? T1H : T0H);
                sh = {sh[6:0], (run > (T0H + T1H) / 2)};
                nbits++;
                if (nbits == 8) begin
                    check("serial_byte", sh, ser_q.pop_front());
                    nbits = 0;
                    nbyte = (nbyte + 1) % 3;
                end
            end
            got_bit = 1'b1; last_hi = run; prev = 1'b0; run = 1;
        end
    end

    task automatic bus(input logic big, input logic w, input logic [13:0] a, input logic [1:0] s,
                       input logic [15:0] d, input logic chk, input logic [15:0] e,
                       input string nm, output logic [15:0] r);
        logic [15:0] ex;
        @(negedge clk);
        cyc = 1'b1; we = w; adr = a; sel = s; dat = d; stb_s = ~big; stb_b = big;
        if (!w && chk) rd_q.push_back(e);
        @(negedge clk);
        cyc = 1'b0; stb_s = 1'b0; stb_b = 1'b0; we = 1'b0;
        r = big ? dat_o_b : dat_o_s;
        if (!w && chk) begin
            ex = rd_q.pop_front();
            check(nm, r, ex);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic big, input logic [13:0] a, input logic [15:0] d);
        logic [15:0] r;
        bus(big, 1'b1, a, 2'b11, d, 1'b0, 16'h0, "", r);
    endtask

    task automatic rdc(input logic big, input logic [13:0] a, input logic [15:0] e, input string nm);
        logic [15:0] r;
        bus(big, 1'b0, a, 2'b11, 16'h0, 1'b1, e, nm, r);
    endtask

    task automatic wait_q(input int n, input int lim, input string nm);
        for (int i = 0; i < lim && ser_q.size() > n; i++) @(negedge clk);
        n_cmp++;
        if (ser_q.size() > n) begin
            n_bad++;
            $display("FAIL %s: timeout with %0d bytes pending, need %0d", nm, ser_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string nm);
        logic [15:0] r;
        r = 16'h1;
        for (int k = 0; k < 1000 && r[0]; k++) begin
            repeat (8) @(negedge clk);
            bus(1'b0, 1'b0, 14'h201, 2'b11, 16'h0, 1'b0, 16'h0, "", r);
        end
        n_cmp++;
        if (r[0]) begin
            n_bad++;
            $display("FAIL %s: still busy, status 0x%0h, expected busy=0", nm, r);
        end
    endtask

    typedef struct {
        logic        we;
        logic [13:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [15:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [13:0] a, input logic [1:0] s,
                                input logic [15:0] d, input logic [15:0] e);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.dat = d; v.exp = e;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        logic [15:0] r;
        int highs;
        tbl[0]  = mk(1, 14'h000, 2'b11, 16'h1234, 0);
        tbl[1]  = mk(0, 14'h000, 2'b11, 0, 16'h1234);
        tbl[2]  = mk(1, 14'h000, 2'b01, 16'hABCD, 0);
        tbl[3]  = mk(0, 14'h000, 2'b11, 0, 16'h12CD);
        tbl[4]  = mk(1, 14'h000, 2'b10, 16'h5600, 0);
        tbl[5]  = mk(0, 14'h000, 2'b11, 0, 16'h56CD);
        tbl[6]  = mk(1, 14'h045, 2'b11, 16'hBEEF, 0);
        tbl[7]  = mk(0, 14'h045, 2'b11, 0, 16'hBEEF);
        tbl[8]  = mk(1, 14'h046, 2'b11, 16'hDEAD, 0);
        tbl[9]  = mk(0, 14'h046, 2'b11, 0, 16'h0000);
        tbl[10] = mk(1, 14'h1FF, 2'b11, 16'hDEAD, 0);
        tbl[11] = mk(0, 14'h1FF, 2'b11, 0, 16'h0000);
        tbl[12] = mk(0, 14'h000, 2'b11, 0, 16'h56CD);
        tbl[13] = mk(0, 14'h045, 2'b11, 0, 16'hBEEF);
        tbl[14] = mk(0, 14'h201, 2'b11, 0, 16'h0000);
        tbl[15] = mk(0, 14'h200, 2'b11, 0, 16'h0000);
        tbl[16] = mk(1, 14'h205, 2'b11, 16'hFFFF, 0);
        tbl[17] = mk(0, 14'h205, 2'b11, 0, 16'h0000);
        tbl[18] = mk(1, 14'h201, 2'b11, 16'hFFFF, 0);
        tbl[19] = mk(0, 14'h201, 2'b11, 0, 16'h0000);
        tbl[20] = mk(1, 14'h200, 2'b11, 16'hFF00, 0);
        tbl[21] = mk(0, 14'h200, 2'b11, 0, BRM);

        cyc = 0; we = 0; stb_s = 0; stb_b = 0; adr = '0; sel = '0; dat = '0;
        nrst_s = 1'b1; nrst_b = 1'b1;
        repeat (3) @(negedge clk);
        nrst_s = 1'b0; nrst_b = 1'b0;
        check("rst_line_small", ser_s, 0);
        check("rst_line_big", ser_b, 0);
        check("rst_dat_o_small", dat_o_s, 0);
        check("rst_dat_o_big", dat_o_b, 0);

        for (int i = 0; i < 22; i++) begin
            bus(1'b1, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, 1'b1, tbl[i].exp,
                $sformatf("vec%0d", i), r);
        end

        // First frame: 00 FF 55, commit while idle
        rdc(0, 14'h201, 16'h0000, "s_status_rst");
        wr(0, 14'h000, 16'hFF00);
        wr(0, 14'h001, 16'h0055);
        wr(0, 14'h200, 16'h0002);
        rdc(0, 14'h201, 16'h0002, "commit_idle_swap");
        mon_en = 1'b1;
        ser_q.push_back(scale(8'h00, 8'hFF));
        ser_q.push_back(scale(8'hFF, 8'hFF));
        ser_q.push_back(scale(8'h55, 8'hFF));
        wr(0, 14'h200, 16'hFF01);
        wait_q(2, 3000, "frame1_byte0");

        // Commit mid-frame: current frame keeps old data, next uses new
        wr(0, 14'h000, 16'hA5C3);
        wr(0, 14'h001, 16'h000F);
        wr(0, 14'h200, 16'hFF03);
        rdc(0, 14'h200, BRM | 16'h0003, "cr_pending");
        rdc(0, 14'h201, 16'h0003, "status_frame1");
        ser_q.push_back(scale(8'hC3, 8'hFF));
        ser_q.push_back(scale(8'hA5, 8'hFF));
        ser_q.push_back(scale(8'h0F, 8'hFF));
        wait_q(2, 8000, "frame2_byte0");
        rdc(0, 14'h201, 16'h0101, "status_frame2");
        rdc(0, 14'h200, BRM | 16'h0001, "cr_after_swap");
        wr(0, 14'h200, 16'hFF00);
        wait_idle("en_clear_idle");
        rdc(0, 14'h201, 16'h0200, "status_idle");
        check("queue_drained", ser_q.size(), 0);
        rdc(0, 14'h000, 16'hFF00, "back_after_swap");
        mon_en = 1'b0;

        // Reset in the middle of a high phase
        wr(0, 14'h200, 16'hFF01);
        for (int i = 0; i < 500 && ser_s !== 1'b1; i++) @(negedge clk);
        check("line_high_before_rst", ser_s, 1);
        nrst_s = 1'b1;
        @(negedge clk);
        check("rst_mid_bit", ser_s, 0);
        @(negedge clk);
        nrst_s = 1'b0;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ser_s !== 1'b0) highs++;
        end
        check("no_resume", highs, 0);
        rdc(0, 14'h201, 16'h0000, "status_post_rst");
        rdc(0, 14'h200, 16'h0000, "cr_post_rst");
        rdc(0, 14'h000, 16'hFF00, "buf_kept_w0");
        rdc(0, 14'h001, 16'h0055, "buf_kept_w1");

        // Brightness 0x7F applied to 00 FF 55
        mon_en = 1'b1;
        ser_q.push_back(scale(8'h00, 8'h7F));
        ser_q.push_back(scale(8'hFF, 8'h7F));
        ser_q.push_back(scale(8'h55, 8'h7F));
        wr(0, 14'h200, 16'h7F03);
        wait_q(2, 3000, "bright_byte0");
        wr(0, 14'h200, 16'h7F00);
        wait_idle("bright_idle");
        check("bright_queue_drained", ser_q.size(), 0);
        rdc(0, 14'h201, 16'h0102, "status_bright");
        mon_en = 1'b0;

        check("big_line_idle", ser_b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
